// File: rtl/psan_sigmoid.sv
// psan_sigmoid: piecewise-linear sigmoid, Q5.10 signed in, Q0.10 unsigned out.
// Four shift-and-add segments on |x|. Negative inputs use f(-x) = 1 - f(x).
// The result is registered, so f_x shows the value of x sampled at the last
// rising clock edge. The active-low reset clears f_x without waiting for a clock.
module psan_sigmoid (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x,
    output logic [15:0] f_x
);

    logic        neg;
    logic [16:0] x_ext;
    logic [16:0] a;
    logic [10:0] shifted;
    logic [10:0] offset;
    logic [10:0] y;
    logic [10:0] res;

    // Magnitude of x in 17 bits, so that 16'h8000 becomes +32768 instead of wrapping.
    always_comb begin
        neg   = x[15];
        x_ext = {x[15], x};
        a     = neg ? (~x_ext + 17'd1) : x_ext;
    end

    // Choose the segment. Each segment supplies a shifted magnitude and an offset.
    // In every segment, a is below that segment's upper boundary. Each slice
    // therefore holds the complete shifted value. Saturation adds 0 to 1024.
    always_comb begin
        shifted = 11'd0;
        offset  = 11'd1024;
        if (a >= 17'd5120) begin
            shifted = 11'd0;
            offset  = 11'd1024;
        end else if (a >= 17'd2432) begin
            shifted = {3'b000, a[12:5]};
            offset  = 11'd864;
        end else if (a >= 17'd1024) begin
            shifted = {2'b00, a[11:3]};
            offset  = 11'd640;
        end else begin
            shifted = {3'b000, a[9:2]};
            offset  = 11'd512;
        end
    end

    // The adder is shared by all segments. Negative inputs are reflected about 0.5.
    always_comb begin
        y   = shifted + offset;
        res = neg ? (11'd1024 - y) : y;
    end

    // Output register. An asynchronous clear discards any result still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_x <= 16'd0;
        end else begin
            f_x <= {5'b00000, res};
        end
    end

endmodule

// File: tb/tb_psan_sigmoid.sv
// Directed testbench for psan_sigmoid: reset, segment table, symmetry,
// one-edge latency, an accuracy sweep over [-8, +8], and asynchronous reset mid-stream.
module tb_psan_sigmoid;

    logic        clk;
    logic        reset;
    logic [15:0] x;
    logic [15:0] f_x;

    int n_vec;
    int n_err;

    logic [15:0] exp_q[$];

    typedef struct {
        string       name;
        logic [15:0] x;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];

    psan_sigmoid dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .f_x   (f_x)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard helpers
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: f_x=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bound(input string name, input real val, input real limit);
        n_vec++;
        if (!(val < limit)) begin
            n_err++;
            $display("FAIL %s: got %f required below %f", name, val, limit);
        end
    endtask

    // Reference sigmoid model, written directly from the segment definitions.
    function automatic logic [15:0] ref_sig(input int xv);
        int mag;
        int yv;
        mag = (xv < 0) ? -xv : xv;
        if (mag >= 5120)      yv = 1024;
        else if (mag >= 2432) yv = mag / 32 + 864;
        else if (mag >= 1024) yv = mag / 8 + 640;
        else                  yv = mag / 4 + 512;
        if (xv < 0) yv = 1024 - yv;
        return 16'(yv);
    endfunction

    // Driver: set x away from the clock edge, then wait one rising edge.
    task automatic apply(input logic [15:0] v);
        @(negedge clk);
        x = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        real sum_err;
        real max_err;
        real fx_r;
        real ideal;
        real err;
        int  xv;
        logic [15:0] lat_x[5];
        logic [15:0] lat_e[5];
        logic [15:0] last;

        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{"seg_x0",       16'd0,      16'd512};
        vecs[1]  = '{"seg_x512",     16'd512,    16'd640};
        vecs[2]  = '{"seg_x1024",    16'd1024,   16'd768};
        vecs[3]  = '{"seg_x2432",    16'd2432,   16'd940};
        vecs[4]  = '{"seg_x2431",    16'd2431,   16'd943};
        vecs[5]  = '{"seg_x5120",    16'd5120,   16'd1024};
        vecs[6]  = '{"seg_x7fff",    16'h7FFF,   16'd1024};
        vecs[7]  = '{"neg_x-1024",   16'hFC00,   16'd256};
        vecs[8]  = '{"neg_x-2560",   16'hF600,   16'd80};
        vecs[9]  = '{"neg_x-6144",   16'hE800,   16'd0};
        vecs[10] = '{"neg_x8000",    16'h8000,   16'd0};

        // Reset held from time zero: f_x must read 0 before any clock edge.
        reset = 1'b0;
        x     = 16'd2560;
        #2;
        check("reset_no_clock", f_x, 16'd0);
        @(posedge clk);
        #1;
        check("reset_held_edge", f_x, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", f_x, 16'd944);

        // Segment and symmetry table
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].x);
            check(vecs[i].name, f_x, vecs[i].exp);
        end

        // Latency: f_x must hold between edges and follow x one edge later.
        lat_x = '{16'd0, 16'd1024, 16'd2560, 16'd5120, 16'hFC00};
        lat_e = '{16'd512, 16'd768, 16'd944, 16'd1024, 16'd256};
        last  = 16'd0;  // the last table entry (16'h8000) leaves f_x at 0
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            x = lat_x[k];
            exp_q.push_back(lat_e[k]);
            #2;
            check("latency_hold", f_x, last);
            @(posedge clk);
            #1;
            last = exp_q.pop_front();
            check("latency_follow", f_x, last);
        end

        // Accuracy sweep over [-8, +8]
        sum_err = 0.0;
        max_err = 0.0;
        for (int i = 0; i < 1000; i++) begin
            xv = -8192 + (i * 16384) / 999;
            apply(16'(xv));
            check("sweep_exact", f_x, ref_sig(xv));
            fx_r  = real'(f_x) / 1024.0;
            ideal = 1.0 / (1.0 + $exp(-real'(xv) / 1024.0));
            err   = fx_r - ideal;
            if (err < 0.0) err = -err;
            sum_err += err;
            if (err > max_err) max_err = err;
        end
        check_bound("sweep_mean_err", sum_err / 1000.0, 0.01);
        check_bound("sweep_max_err", max_err, 0.02);

        // Asynchronous reset mid-stream while f_x holds 944
        apply(16'd2560);
        check("mid_pre", f_x, 16'd944);
        #2;
        reset = 1'b0;
        #1;
        check("mid_async_clear", f_x, 16'd0);
        @(posedge clk);
        #1;
        check("mid_held", f_x, 16'd0);
        @(negedge clk);
        x     = 16'd1024;
        reset = 1'b1;
        #1;
        check("mid_release_no_edge", f_x, 16'd0);
        @(posedge clk);
        #1;
        check("mid_resume", f_x, 16'd768);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
